miller_tx_framer: RTL and testbench

MILLER_TX_FRAMER -- requirements
Module: miller_tx_framer

---
 rtl/miller_pkg.sv | 19 +
 rtl/miller_tx_framer.sv | 161 ++++++++++++++++
 tb/tb_miller_tx_framer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/miller_pkg.sv
// Shared types and constants for the Miller transmit framer.
package miller_pkg;

  localparam int BYTE_W = 8;
  localparam int CNT_W  = 8;

  localparam logic [BYTE_W-1:0] PREAMBLE_BYTE_DEF = 8'hAA;
  localparam logic [BYTE_W-1:0] SOF_BYTE_DEF      = 8'h7E;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SOF,
    ST_LEN,
    ST_PAY,
    ST_CHK
  } state_t;

endpackage

// File: rtl/miller_tx_framer.sv
// Byte framer feeding a Miller encoder: preamble, SOF, length, payload, XOR checksum.
//
// state | meaning
// ------+-------------------------------------------------------------------
// IDLE  | no frame; first in_valid starts one
// PRE   | next byte loaded into the output register is a preamble byte
// SOF   | next byte loaded is the start-of-frame byte
// LEN   | next byte loaded is the length byte; checksum seeded with it
// PAY   | payload bytes pass straight from the producer into the output register
// CHK   | checksum loaded (r_cnt 0 -> 1), then held until the encoder takes it
//
// The state names the field being loaded into the single output register.
// Loading the next byte happens on the same edge the current one transfers,
// so with out_ready high the frame streams with no bubbles.
module miller_tx_framer
  import miller_pkg::*;
#(
  parameter int unsigned        PAYLOAD_LEN   = 12,
  parameter int unsigned        PREAMBLE_LEN  = 2,
  parameter logic [BYTE_W-1:0]  PREAMBLE_BYTE = PREAMBLE_BYTE_DEF,
  parameter logic [BYTE_W-1:0]  SOF_BYTE      = SOF_BYTE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);
  localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(PAYLOAD_LEN - 1);
  localparam logic [CNT_W-1:0] LEN_BYTE = CNT_W'(PAYLOAD_LEN);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [BYTE_W-1:0]  r_chk;
  logic [BYTE_W-1:0]  r_out_data;
  logic               r_out_valid;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [BYTE_W-1:0]  w_chk_nxt;
  logic [BYTE_W-1:0]  w_data_nxt;
  logic               w_valid_nxt;
  logic               w_in_ready;
  logic               w_frame_done;
  logic               w_xfer;
  logic               w_load;

  // Next-state, datapath and handshake decode
  always_comb begin
    w_xfer       = r_out_valid & out_ready;
    w_load       = ~r_out_valid | out_ready;
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_chk_nxt    = r_chk;
    w_data_nxt   = r_out_data;
    w_valid_nxt  = r_out_valid & ~out_ready;
    w_in_ready   = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_state_nxt = ST_PRE;
          w_cnt_nxt   = '0;
        end
      end
      ST_PRE: begin
        if (w_load) begin
          w_data_nxt  = PREAMBLE_BYTE;
          w_valid_nxt = 1'b1;
          if (r_cnt == PRE_LAST) begin
            w_state_nxt = ST_SOF;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      ST_SOF: begin
        if (w_load) begin
          w_data_nxt  = SOF_BYTE;
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_LEN;
        end
      end
      ST_LEN: begin
        if (w_load) begin
          w_data_nxt  = LEN_BYTE;
          w_valid_nxt = 1'b1;
          w_chk_nxt   = LEN_BYTE;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_PAY;
        end
      end
      ST_PAY: begin
        w_in_ready = (r_cnt < LEN_BYTE) & w_load;
        if (in_valid & w_in_ready) begin
          w_data_nxt  = in_data;
          w_valid_nxt = 1'b1;
          w_chk_nxt   = r_chk ^ in_data;
          if (r_cnt == PAY_LAST) begin
            w_state_nxt = ST_CHK;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      ST_CHK: begin
        if (r_cnt == '0) begin
          if (w_load) begin
            w_data_nxt  = r_chk;
            w_valid_nxt = 1'b1;
            w_cnt_nxt   = CNT_W'(1);
          end
        end else if (w_xfer) begin
          w_frame_done = 1'b1;
          w_state_nxt  = ST_IDLE;
          w_cnt_nxt    = '0;
          w_chk_nxt    = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_chk_nxt   = '0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // State, counter, checksum and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_chk       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_chk       <= w_chk_nxt;
      r_out_data  <= w_data_nxt;
      r_out_valid <= w_valid_nxt;
    end
  end

  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign in_ready   = w_in_ready;
  assign busy       = (r_state != ST_IDLE);
  assign frame_done = w_frame_done;

endmodule

// File: tb/tb_miller_tx_framer.sv
// Scoreboard bench for miller_tx_framer: frame bytes are queued as they are
// committed by the stimulus and checked as the encoder side takes them.
module tb_miller_tx_framer;

  localparam int PL = 12;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       frame_done;

  int         n_cmp = 0;
  int         n_mis = 0;
  logic [7:0] sb[$];
  logic [7:0] pay[PL];
  int         xfer_cyc[$];
  int         fd_cnt = 0;
  int         cyc = 0;

  miller_tx_framer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs == exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Encoder-side monitor: pops the scoreboard on every transfer, checks hold-while-stalled
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    logic [7:0] exp;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (frame_done) fd_cnt++;
        if (prev_stall) begin
          check1("hold_valid", out_valid, 1'b1);
          check8("hold_data", out_data, prev_data);
        end
        if (out_valid && out_ready) begin
          xfer_cyc.push_back(cyc);
          n_cmp++;
          assert (sb.size() > 0) else begin
            n_mis++;
            $error("FAIL unexpected_byte observed=%02h expected=none", out_data);
          end
          if (sb.size() > 0) begin
            exp = sb.pop_front();
            check8("out_byte", out_data, exp);
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // One frame, stepped cycle by cycle from just after a rising edge
  task automatic run_frame(input int rdy_period, input int gap_after, input int gap_len,
                           input int abort_at, input int budget, input bit chk_stream);
    int         sent, gap_left, n, fd_base, xb;
    logic [7:0] chk;
    bit         done, aborted, accept;
    sent = 0; gap_left = 0; n = 0; done = 0; aborted = 0;
    chk = 8'(PL);
    fd_base = fd_cnt;
    xb = xfer_cyc.size();
    sb.push_back(8'hAA);
    sb.push_back(8'hAA);
    sb.push_back(8'h7E);
    sb.push_back(8'(PL));
    in_valid  = 1'b1;
    in_data   = pay[0];
    out_ready = ((n % rdy_period) == rdy_period - 1);
    while (!done && n < budget) begin
      @(negedge clk);
      accept = in_valid && in_ready;
      @(posedge clk);
      #1;
      n++;
      if (accept) begin
        sb.push_back(in_data);
        chk ^= in_data;
        sent++;
        if (sent == PL) sb.push_back(chk);
        if (sent == gap_after) gap_left = gap_len;
      end
      out_ready = ((n % rdy_period) == rdy_period - 1);
      if (abort_at > 0 && sent == abort_at) begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check1("abort_out_valid", out_valid, 1'b0);
        check1("abort_busy", busy, 1'b0);
        check1("abort_in_ready", in_ready, 1'b0);
        check8("abort_out_data", out_data, 8'h00);
        sb.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        aborted = 1;
        done    = 1;
      end else if (gap_left > 0) begin
        in_valid = 1'b0;
        gap_left--;
        if (gap_left == 2) check1("gap_out_valid_low", out_valid, 1'b0);
      end else begin
        in_valid = (sent < PL);
        in_data  = (sent < PL) ? pay[sent[3:0]] : 8'h00;
      end
      if (sent == PL && sb.size() == 0) done = 1;
    end
    check1("frame_complete", done, 1'b1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    if (!aborted) begin
      check_int("frame_done_pulses", fd_cnt - fd_base, 1);
      check_int("sb_drained", sb.size(), 0);
      check1("idle_after_frame", busy, 1'b0);
    end
    if (chk_stream) begin
      check_int("stream_count", xfer_cyc.size() - xb, 17);
      if (xfer_cyc.size() - xb == 17)
        check_int("stream_span", xfer_cyc[xfer_cyc.size() - 1] - xfer_cyc[xb], 16);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  // Directed sequence
  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h55;
    out_ready = 1'b1;
    #12;
    check1("rst_out_valid", out_valid, 1'b0);
    check8("rst_out_data", out_data, 8'h00);
    check1("rst_in_ready", in_ready, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_frame_done", frame_done, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;

    repeat (20) @(posedge clk);
    #1;
    check1("idle20_busy", busy, 1'b0);
    check1("idle20_out_valid", out_valid, 1'b0);
    check1("idle20_in_ready", in_ready, 1'b0);

    for (int i = 0; i < PL; i++) pay[i] = 8'(i);
    run_frame(1, -1, 0, -1, 100, 1'b1);

    run_frame(16, -1, 0, -1, 600, 1'b0);

    for (int i = 0; i < PL; i++) pay[i] = 8'hFF;
    run_frame(1, -1, 0, -1, 100, 1'b0);

    for (int i = 0; i < PL; i++) pay[i] = (i % 2 == 0) ? 8'h7E : 8'hAA;
    run_frame(1, -1, 0, -1, 100, 1'b0);

    for (int i = 0; i < PL; i++) pay[i] = 8'(i * 19 + 5);
    run_frame(1, 4, 5, -1, 100, 1'b0);

    for (int i = 0; i < PL; i++) pay[i] = 8'(i);
    run_frame(1, -1, 0, 6, 100, 1'b0);
    run_frame(1, -1, 0, -1, 100, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
